// File: rtl/bus_arbiter_pkg.sv
// Shared widths, FSM state encoding and the latched-transaction record for
// the two-port bus arbiter.
package bus_arbiter_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 64;
  localparam int TAG_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic              grant;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [TAG_W-1:0]  wtag;
  } txn_t;

endpackage

// File: rtl/bus_arbiter_pick.sv
// Combinational grant selection between the two requesters.
// BUS_ARBITER_RR_EN selects round-robin tie breaking; otherwise port 0 wins ties.
module bus_arbiter_pick (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic last_grant_i,
  output logic grant_any_o,
  output logic grant_id_o
);

  assign grant_any_o = valid0_i | valid1_i;

`ifdef BUS_ARBITER_RR_EN
  // On a tie the port that did not win the previous grant goes next.
  assign grant_id_o = valid1_i & (~valid0_i | ~last_grant_i);
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
  assign grant_id_o        = valid1_i & ~valid0_i;
`endif

endmodule

// File: rtl/bus_arbiter.sv
// Two-port arbiter driving a multiplexed address/data bus: IDLE -> ADDR -> DATA -> DONE.
// Optional round-robin tie breaking with BUS_ARBITER_RR_EN (fixed priority to port 0 otherwise).
module bus_arbiter
  import bus_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic [TAG_W-1:0]  req0_wtag,
  output logic              req0_ack,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic [TAG_W-1:0]  req1_wtag,
  output logic              req1_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [TAG_W-1:0]  rtag,
  input  logic [DATA_W-1:0] i_data,
  input  logic [TAG_W-1:0]  i_tag,
  output logic [DATA_W-1:0] o_ad,
  output logic [TAG_W-1:0]  o_tag,
  output logic              o_astb,
  output logic              o_rd,
  output logic              o_wr,
  output logic              busy
);

  state_e            state_q, state_d;
  txn_t              txn_q, txn_d;
  logic [DATA_W-1:0] ad_q, ad_d, rdata_q, rdata_d;
  logic [TAG_W-1:0]  tag_q, tag_d, rtag_q, rtag_d;
  logic              astb_q, astb_d, rd_q, rd_d, wr_q, wr_d;
  logic [1:0]        ack_q, ack_d;
  logic              grant_any, grant_id, last_grant;

  bus_arbiter_pick u_pick (
    .valid0_i     (req0_valid),
    .valid1_i     (req1_valid),
    .last_grant_i (last_grant),
    .grant_any_o  (grant_any),
    .grant_id_o   (grant_id)
  );

`ifdef BUS_ARBITER_RR_EN
  logic last_grant_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          last_grant_q <= 1'b1;
    else if (state_q == IDLE && grant_any) last_grant_q <= grant_id;
  end
  assign last_grant = last_grant_q;
`else
  assign last_grant = 1'b1;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    txn_d   = txn_q;
    unique case (state_q)
      IDLE: if (grant_any) begin
        state_d     = ADDR;
        txn_d.grant = grant_id;
        txn_d.we    = grant_id ? req1_we    : req0_we;
        txn_d.addr  = grant_id ? req1_addr  : req0_addr;
        txn_d.wdata = grant_id ? req1_wdata : req0_wdata;
        txn_d.wtag  = grant_id ? req1_wtag  : req0_wtag;
      end
      ADDR:    state_d = DATA;
      DATA:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so the registered copies line up with the FSM.
  always_comb begin
    ad_d    = '0;
    tag_d   = '0;
    astb_d  = 1'b0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    ack_d   = 2'b00;
    rdata_d = rdata_q;
    rtag_d  = rtag_q;
    unique case (state_d)
      ADDR: begin
        astb_d = 1'b1;
        ad_d   = DATA_W'(txn_d.addr);
        rd_d   = ~txn_d.we;
        wr_d   = txn_d.we;
      end
      DATA: begin
        if (txn_d.we) begin
          ad_d  = txn_d.wdata;
          tag_d = txn_d.wtag;
          wr_d  = 1'b1;
        end else begin
          rd_d  = 1'b1;
        end
      end
      DONE:    ack_d[txn_d.grant] = 1'b1;
      default: ;
    endcase
    if (state_q == DATA && !txn_q.we) begin
      rdata_d = i_data;
      rtag_d  = i_tag;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      txn_q   <= '0;
      ad_q    <= '0;
      tag_q   <= '0;
      astb_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ack_q   <= 2'b00;
      rdata_q <= '0;
      rtag_q  <= '0;
    end else begin
      state_q <= state_d;
      txn_q   <= txn_d;
      ad_q    <= ad_d;
      tag_q   <= tag_d;
      astb_q  <= astb_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      rtag_q  <= rtag_d;
    end
  end

  assign o_ad     = ad_q;
  assign o_tag    = tag_q;
  assign o_astb   = astb_q;
  assign o_rd     = rd_q;
  assign o_wr     = wr_q;
  assign req0_ack = ack_q[0];
  assign req1_ack = ack_q[1];
  assign rdata    = rdata_q;
  assign rtag     = rtag_q;
  assign busy     = (state_q != IDLE);

endmodule
